// File: rtl/cordic_pkg.sv
// Shared constants and tag type for the CORDIC trig arbiter.
// Angles and results are signed Q2.14; HALF_PI is pi/2 in that format.
package cordic_pkg;
  localparam int          DATA_W   = 16;
  localparam int          PIPE_LAT = 10;
  localparam int          TAG_ID_W = 8;
  localparam logic [15:0] HALF_PI  = 16'h6488;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, zero latency.
// Search starts at ptr; ptr moves past the winner only when a grant is made.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_vld,
  output logic [ID_W-1:0]    gnt_id
);
  logic [ID_W-1:0] ptr;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt_id   = ID_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
endmodule

// File: rtl/cordic_trig_arb.sv
// Shares one CORDIC sin/cos pipeline among NUM_REQ requesters; result valid PIPE_LAT+2 cycles after grant,
// one outstanding op per requester, results held until rsp_ready. CORDIC_TRIG_ARB_CLAMP_EN clamps angles to +/-pi/2.
module cordic_trig_arb #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = cordic_pkg::DATA_W,
  parameter int PIPE_LAT = cordic_pkg::PIPE_LAT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_rad,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*DATA_W-1:0] rsp_sin,
  output logic [NUM_REQ*DATA_W-1:0] rsp_cos,
  output logic                      pipe_valid,
  output logic [DATA_W-1:0]         pipe_rad,
  input  logic [DATA_W-1:0]         pipe_sin,
  input  logic [DATA_W-1:0]         pipe_cos
);
  import cordic_pkg::*;

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_hs;
  logic [NUM_REQ-1:0] cap;
  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    pipe_id;
  logic [ID_W-1:0]    tail_id;
  logic [DATA_W-1:0]  sel_rad;
  logic [DATA_W-1:0]  iss_rad;
  tag_t               tags [PIPE_LAT];

  assign rsp_hs    = rsp_valid & rsp_ready;
  assign req_ready = gnt;

  // busy stays set through the response handshake cycle, so no same-cycle re-grant
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req_valid & ~busy),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign sel_rad = req_rad[int'(gnt_id)*DATA_W +: DATA_W];

`ifdef CORDIC_TRIG_ARB_CLAMP_EN
  localparam logic signed [DATA_W-1:0] POS_LIM = DATA_W'(HALF_PI);
  localparam logic signed [DATA_W-1:0] NEG_LIM = -POS_LIM;

  always_comb begin
    iss_rad = sel_rad;
    if ($signed(sel_rad) > POS_LIM) begin
      iss_rad = POS_LIM;
    end else if ($signed(sel_rad) < NEG_LIM) begin
      iss_rad = NEG_LIM;
    end
  end
`else
  assign iss_rad = sel_rad;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_valid <= 1'b0;
      pipe_rad   <= '0;
      pipe_id    <= '0;
      busy       <= '0;
    end else begin
      pipe_valid <= gnt_vld;
      if (gnt_vld) begin
        pipe_rad <= iss_rad;
        pipe_id  <= gnt_id;
      end
      busy <= (busy & ~rsp_hs) | gnt;
    end
  end

  // Tag travels beside the pipeline so the tail lines up with pipe_sin/pipe_cos.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= '{vld: pipe_valid, id: TAG_ID_W'(pipe_id)};
      for (int i = 1; i < PIPE_LAT; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  assign tail_id = ID_W'(tags[PIPE_LAT-1].id);

  always_comb begin
    cap = '0;
    if (tags[PIPE_LAT-1].vld) begin
      cap[tail_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= '0;
      rsp_sin   <= '0;
      rsp_cos   <= '0;
    end else begin
      rsp_valid <= (rsp_valid & ~rsp_hs) | cap;
      if (tags[PIPE_LAT-1].vld) begin
        rsp_sin[int'(tail_id)*DATA_W +: DATA_W] <= pipe_sin;
        rsp_cos[int'(tail_id)*DATA_W +: DATA_W] <= pipe_cos;
      end
    end
  end
endmodule

// File: tb/tb_cordic_trig_arb.sv
// Directed bench for cordic_trig_arb with a fixed-latency stand-in pipeline.
module tb_cordic_trig_arb;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 10;
`ifdef CORDIC_TRIG_ARB_CLAMP_EN
  localparam logic [15:0] CL_POS = 16'h6488;
  localparam logic [15:0] CL_NEG = 16'h9B78;
`else
  localparam logic [15:0] CL_POS = 16'h7000;
  localparam logic [15:0] CL_NEG = 16'h8800;
`endif

  logic           clk;
  logic           rstn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_rad;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [N*W-1:0] rsp_sin;
  logic [N*W-1:0] rsp_cos;
  logic           pipe_valid;
  logic [W-1:0]   pipe_rad;
  logic [W-1:0]   pipe_sin;
  logic [W-1:0]   pipe_cos;

  int tests_run;
  int tests_failed;
  int cyc;
  int rv_cnt;
  int gq[$];
  logic [15:0] exp_rad [N];
  logic [31:0] mon_exp;
  logic [15:0] dl [LAT];

  cordic_trig_arb #(.NUM_REQ(N), .DATA_W(W), .PIPE_LAT(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rad    (req_rad),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sin    (rsp_sin),
    .rsp_cos    (rsp_cos),
    .pipe_valid (pipe_valid),
    .pipe_rad   (pipe_rad),
    .pipe_sin   (pipe_sin),
    .pipe_cos   (pipe_cos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stand-in pipeline: sin(0.5)/cos(0.5) for 0x2000, a signature of the angle otherwise.
  function automatic logic [31:0] model(input logic [15:0] r);
    if (r == 16'h2000) return {16'h1EAF, 16'h382A};
    return {r ^ 16'h5A5A, r + 16'h0123};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dl[0] <= pipe_rad;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end
  assign {pipe_sin, pipe_cos} = model(dl[LAT-1]);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (|req_ready) begin
        check_eq("grant_onehot", $countones(req_ready), 1);
        for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
      end
      if (|rsp_valid) rv_cnt++;
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          mon_exp = model(exp_rad[i]);
          check_eq($sformatf("rsp_sin%0d", i), rsp_sin[i*W +: W], mon_exp[31:16]);
          check_eq($sformatf("rsp_cos%0d", i), rsp_cos[i*W +: W], mon_exp[15:0]);
        end
      end
    end
  end

  initial begin
    int t0, tr, found, chg, n0, n1, n2, n3;
    logic [5:0]  pv;
    logic [31:0] snap;
    tests_run = 0; tests_failed = 0; cyc = 0; rv_cnt = 0;
    rstn = 1'b0; req_valid = '0; rsp_ready = '0; req_rad = '0;
    for (int i = 0; i < N; i++) exp_rad[i] = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pipe_valid", pipe_valid, 0);
    check_eq("rst_pipe_rad", pipe_rad, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_sin", rsp_sin[31:0], 0);
    check_eq("rst_rsp_cos", rsp_cos[31:0], 0);
    check_eq("rst_req_ready", req_ready, 0);
    step();
    rstn = 1'b1;

    // single request, latency and payload
    step();
    req_rad[0 +: W] = 16'h2000; exp_rad[0] = 16'h2000; req_valid = 4'b0001;
    @(negedge clk);
    check_eq("t1_grant", req_ready, 4'b0001);
    t0 = cyc;
    step();
    req_valid = '0;
    @(negedge clk);
    check_eq("t1_issue_vld", pipe_valid, 1);
    check_eq("t1_issue_rad", pipe_rad, 16'h2000);
    found = 0; tr = -1;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin found = 1; tr = cyc; end
    end
    check_eq("t1_rsp_lat", tr - t0, 12);
    check_eq("t1_sin_tol", (int'(rsp_sin[15:0]) - 'h1EAF <= 8 && 'h1EAF - int'(rsp_sin[15:0]) <= 8)
             ? 32'h1EAF : {16'h0, rsp_sin[15:0]}, 32'h1EAF);
    check_eq("t1_cos_tol", (int'(rsp_cos[15:0]) - 'h382A <= 8 && 'h382A - int'(rsp_cos[15:0]) <= 8)
             ? 32'h382A : {16'h0, rsp_cos[15:0]}, 32'h382A);
    repeat (3) step();
    @(negedge clk);
    check_eq("t1_hold_vld", rsp_valid[0], 1);
    check_eq("t1_hold_sin", rsp_sin[15:0], 16'h1EAF);

    // response handshake and new request on the same requester
    step();
    req_valid = 4'b0001; rsp_ready = 4'b0001;
    @(negedge clk);
    check_eq("c_no_regrant", req_ready, 0);
    step();
    @(negedge clk);
    check_eq("c1_rsp_clr", rsp_valid[0], 0);
    check_eq("c1_regrant", req_ready, 4'b0001);
    step();
    req_valid = '0; rsp_ready = '1;
    repeat (16) step();

    // reset mid-operation
    req_rad[0*W +: W] = 16'h0300; req_rad[1*W +: W] = 16'h0400; req_rad[2*W +: W] = 16'h0500;
    for (int i = 0; i < 3; i++) exp_rad[i] = req_rad[i*W +: W];
    req_valid = 4'b0111;
    repeat (3) step();
    req_valid = '0;
    repeat (2) step();
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_pipe_vld", pipe_valid, 0);
    check_eq("mid_rst_pipe_rad", pipe_rad, 0);
    check_eq("mid_rst_rsp_vld", rsp_valid, 0);
    check_eq("mid_rst_rsp_sin", rsp_sin[47:0], 0);
    check_eq("mid_rst_rsp_cos", rsp_cos[47:0], 0);
    check_eq("mid_rst_req_rdy", req_ready, 0);
    repeat (2) step();
    rstn = 1'b1;
    rv_cnt = 0;
    repeat (25) step();
    @(negedge clk);
    check_eq("mid_rst_no_rsp", rv_cnt, 0);

    // all requesters continuously valid
    gq.delete();
    step();
    for (int i = 0; i < N; i++) begin
      req_rad[i*W +: W] = 16'(16'h0100 * (i + 1));
      exp_rad[i] = 16'(16'h0100 * (i + 1));
    end
    rsp_ready = '1; req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pv[k] = pipe_valid;
      step();
    end
    check_eq("rr_pipe_burst", pv, 6'b011110);
    repeat (30) step();
    check_eq("rr_gq_len", gq.size() >= 8, 1);
    for (int i = 0; i < 8; i++) check_eq($sformatf("rr_order%0d", i), gq[i], i % 4);
    req_valid = '0;
    repeat (20) step();

    // requester 2 withholds rsp_ready
    gq.delete();
    rsp_ready = 4'b1011; req_valid = '1;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (rsp_valid[2]) found = 1;
    end
    check_eq("hold_rsp2_seen", found, 1);
    snap = {rsp_sin[2*W +: W], rsp_cos[2*W +: W]};
    chg = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid[2] || {rsp_sin[2*W +: W], rsp_cos[2*W +: W]} != snap) chg++;
    end
    check_eq("hold_stable", chg, 0);
    check_eq("hold_payload", snap, model(16'h0300));
    n0 = 0; n1 = 0; n2 = 0; n3 = 0;
    foreach (gq[i]) begin
      if (gq[i] == 0) n0++;
      if (gq[i] == 1) n1++;
      if (gq[i] == 2) n2++;
      if (gq[i] == 3) n3++;
    end
    check_eq("hold_no_regrant2", n2, 1);
    check_eq("hold_srv0", n0 >= 2, 1);
    check_eq("hold_srv1", n1 >= 2, 1);
    check_eq("hold_srv3", n3 >= 2, 1);
    step();
    rsp_ready = '1; req_valid = '0;
    repeat (20) step();

    // angle clamp (or pass-through)
    req_rad[1*W +: W] = 16'h7000; exp_rad[1] = CL_POS; req_valid = 4'b0010;
    step();
    req_rad[3*W +: W] = 16'h8800; exp_rad[3] = CL_NEG; req_valid = 4'b1000;
    @(negedge clk);
    check_eq("clamp_pos", pipe_rad, CL_POS);
    step();
    req_valid = '0;
    @(negedge clk);
    check_eq("clamp_neg", pipe_rad, CL_NEG);
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/cordic_trig_arb.md
CORDIC_TRIG_ARB -- requirements
Module: cordic_trig_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one CORDIC trig pipeline.
REQ-002 SHALL have parameter DATA_W, default 16: fixed-point angle/result width (1 sign, 1 integer, 14 fraction bits).
REQ-003 SHALL have parameter PIPE_LAT, default 10: the pipeline's fixed latency in cycles, from pipe_valid to the matching pipe_sin/pipe_cos.
REQ-004 SHALL have these ports, one per line, clock and reset first:
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted.
- req_rad  in  NUM_REQ*DATA_W  per-requester angle; requester i occupies slice i.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_ready  in  NUM_REQ  per-requester result consumed.
- rsp_sin  out  NUM_REQ*DATA_W  per-requester sine result.
- rsp_cos  out  NUM_REQ*DATA_W  per-requester cosine result.
- pipe_valid  out  1  issue strobe to the pipeline.
- pipe_rad  out  DATA_W  angle to the pipeline.
- pipe_sin  in  DATA_W  pipeline sine output.
- pipe_cos  in  DATA_W  pipeline cosine output.

Function
REQ-005 SHALL keep a per-requester busy flag: set on a request handshake (req_valid & req_ready), cleared in the cycle after a response handshake (rsp_valid & rsp_ready); each requester has at most one outstanding transaction.
REQ-006 SHALL make requester i eligible when req_valid[i] is high and busy[i] is low; at most one req_ready bit is high per cycle; req_ready is combinational from req_valid and state.
REQ-007 SHALL arbitrate round-robin: search starts at pointer ptr; after a grant to requester g, ptr becomes (g+1) mod NUM_REQ; ptr is unchanged when there is no grant.
REQ-008 SHALL register the issue: a handshake in cycle T drives pipe_valid=1 and pipe_rad=granted angle in cycle T+1; otherwise pipe_valid=0 and pipe_rad holds its value.
REQ-009 SHALL carry a PIPE_LAT-deep tag shift register of {valid, requester id} alongside the pipeline; the tag for an issue in cycle T+1 reaches the tail in cycle T+1+PIPE_LAT.
REQ-010 SHALL capture pipe_sin/pipe_cos into the tagged requester's result slot when the tail tag is valid; rsp_valid of that requester rises in cycle T+PIPE_LAT+2.
REQ-011 SHALL hold rsp_valid, rsp_sin and rsp_cos stable until rsp_ready; rsp_valid clears in the cycle after the handshake.
REQ-012 SHALL NOT re-grant a requester in the same cycle as its response handshake; busy is still set that cycle.
REQ-013 SHALL sustain one issue per cycle when different requesters are eligible; the pipeline itself has no backpressure.

Reset
REQ-014 SHALL, on rstn low, asynchronously clear busy, ptr (to 0), every tag valid bit, pipe_valid, pipe_rad, rsp_valid, rsp_sin and rsp_cos to zero.
REQ-015 SHALL discard in-flight results on reset mid-operation; pipeline outputs with no valid tag are ignored.

Configuration
REQ-016 SHALL, with macro CORDIC_TRIG_ARB_CLAMP_EN defined, saturate the issued angle to [-HALF_PI, +HALF_PI] = [0x9B78, 0x6488].
REQ-017 SHALL, without CORDIC_TRIG_ARB_CLAMP_EN, pass req_rad to pipe_rad unmodified.

Structure
REQ-018 SHALL place DATA_W, PIPE_LAT, HALF_PI and the tag struct typedef in shared package cordic_pkg.
REQ-019 SHALL implement arbitration in sub-module rr_arbiter (NUM_REQ request/grant vectors, pointer update on grant).

Verification
REQ-020 Verification: reset, then single request from requester 0 with req_rad=0x2000 (0.5 rad) in cycle T -> rsp_valid[0] in cycle T+12, rsp_sin=0x1EAF, rsp_cos=0x382A, each within +/-8 LSB.
REQ-021 Verification: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; pipe_valid high 4 consecutive cycles.
REQ-022 Verification: requester 2 holds rsp_ready=0 for 20 cycles with req_valid high -> no further grant to 2; rsp payload stable; others still served.
REQ-023 Verification: rstn asserted 5 cycles after issuing 3 requests -> all outputs zero immediately; no rsp_valid after release.
REQ-024 Verification: CORDIC_TRIG_ARB_CLAMP_EN defined, req_rad=0x7000 -> pipe_rad=0x6488; undefined -> pipe_rad=0x7000.
REQ-025 Verification: response handshake and req_valid on the same requester in cycle C -> req_ready low in C, grant no earlier than C+1.
